// File: rtl/tx_stream_arbiter_if.sv
// ---------------------------------------------------------------------------
// tx_stream_arbiter_if
// Bundles the stb/ack word-stream signals around tx_stream_arbiter.
//
// Handshake: a word moves on either side when its stb and ack are both high
// at the same rising edge of clk. A producer raises stb with its data and
// holds both steady until it sees ack. The arbiter raises output_stream_stb
// with data and tag and holds all three steady until output_stream_ack.
//
// Signals
//   input_streams       CHANNELS*WIDTH  channel c data at [c*WIDTH +: WIDTH]
//   input_streams_stb   CHANNELS        per-channel valid
//   input_streams_ack   CHANNELS        per-channel accept (one-hot or zero)
//   output_stream       WIDTH           forwarded word
//   output_stream_chan  CHAN_BITS       source channel of output_stream
//   output_stream_stb   1               output valid
//   output_stream_ack   1               consumer accept
//   output_count        32              words delivered since reset
// Modports
//   master  arbiter side (drives acks and the output stream)
//   slave   producer/consumer side
// ---------------------------------------------------------------------------
interface tx_stream_arbiter_if #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 32,
   parameter int CHAN_BITS = 2
);
   logic [CHANNELS*WIDTH-1:0] input_streams;
   logic [CHANNELS-1:0]       input_streams_stb;
   logic [CHANNELS-1:0]       input_streams_ack;
   logic [WIDTH-1:0]          output_stream;
   logic [CHAN_BITS-1:0]      output_stream_chan;
   logic                      output_stream_stb;
   logic                      output_stream_ack;
   logic [31:0]               output_count;

   modport master (
      input  input_streams, input_streams_stb, output_stream_ack,
      output input_streams_ack, output_stream, output_stream_chan,
      output output_stream_stb, output_count
   );

   modport slave (
      output input_streams, input_streams_stb, output_stream_ack,
      input  input_streams_ack, output_stream, output_stream_chan,
      input  output_stream_stb, output_count
   );
endinterface

// File: rtl/tx_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tx_stream_arbiter
// Round-robin merger of CHANNELS stb/ack word streams into one output
// stream. One word is moved at a time through IDLE -> ACCEPT -> SEND, tagged
// with its source channel, and every delivered word bumps output_count.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   bus        tx_stream_arbiter_if.master (all stream signals)
//   dbg_state  current FSM state (0 IDLE, 1 ACCEPT, 2 SEND)
//
// Optional feature
//   TX_STREAM_ARB_BURST_EN: when defined, the channel that delivered the last
//   word may be regranted up to BURST consecutive words while it keeps
//   requesting. When undefined the grant rotates after every word.
// ---------------------------------------------------------------------------
module tx_stream_arbiter #(
   parameter int CHANNELS  = 4,
   parameter int WIDTH     = 32,
   parameter int CHAN_BITS = 2,
   parameter int BURST     = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   tx_stream_arbiter_if.master     bus,
   output logic [1:0]              dbg_state
);

   if (BURST < 1 || (2 ** CHAN_BITS) < CHANNELS) begin : g_bad_params
      $error("tx_stream_arbiter: invalid BURST or CHAN_BITS");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      SEND   = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CHAN_BITS-1:0] grant_q, grant_d;
   logic [CHAN_BITS-1:0] last_grant_q, last_grant_d;
   logic [CHANNELS-1:0]  ack_q, ack_d;
   logic [WIDTH-1:0]     data_q, data_d;
   logic [CHAN_BITS-1:0] chan_q, chan_d;
   logic                 ostb_q, ostb_d;
   logic [31:0]          count_q, count_d;

`ifdef TX_STREAM_ARB_BURST_EN
   localparam int BCW = $clog2(BURST + 1);
   logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
   // Low until the first grant after reset, so the reset value of
   // last_grant is never treated as a channel that is mid-burst.
   logic           burst_vld_q, burst_vld_d;
`endif

   // First requester after last_grant, searching upward with wrap.
   logic [CHAN_BITS-1:0] rr_sel;
   logic                 rr_found;

   always_comb begin
      rr_sel   = '0;
      rr_found = 1'b0;
      for (int i = 1; i <= CHANNELS; i++) begin
         if (!rr_found && bus.input_streams_stb[(int'(last_grant_q) + i) % CHANNELS]) begin
            rr_found = 1'b1;
            rr_sel   = CHAN_BITS'((int'(last_grant_q) + i) % CHANNELS);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      ack_d        = '0;
      data_d       = data_q;
      chan_d       = chan_q;
      ostb_d       = ostb_q;
      count_d      = count_q;
`ifdef TX_STREAM_ARB_BURST_EN
      burst_cnt_d  = burst_cnt_q;
      burst_vld_d  = burst_vld_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (rr_found) begin
`ifdef TX_STREAM_ARB_BURST_EN
               if (burst_vld_q && bus.input_streams_stb[last_grant_q] &&
                   int'(burst_cnt_q) < BURST - 1) begin
                  grant_d     = last_grant_q;
                  burst_cnt_d = burst_cnt_q + BCW'(1);
               end else begin
                  grant_d     = rr_sel;
                  burst_cnt_d = '0;
               end
               burst_vld_d = 1'b1;
`else
               grant_d = rr_sel;
`endif
               ack_d[grant_d] = 1'b1;
               state_d        = ACCEPT;
            end
         end
         ACCEPT: begin
            // ack_q[grant_q] is high this cycle, so the word transfers at the
            // closing edge; capture it here.
            data_d  = bus.input_streams[int'(grant_q) * WIDTH +: WIDTH];
            chan_d  = grant_q;
            ostb_d  = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (bus.output_stream_ack) begin
               ostb_d       = 1'b0;
               count_d      = count_q + 32'd1;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= CHAN_BITS'(CHANNELS - 1);
         ack_q        <= '0;
         data_q       <= '0;
         chan_q       <= '0;
         ostb_q       <= 1'b0;
         count_q      <= '0;
`ifdef TX_STREAM_ARB_BURST_EN
         burst_cnt_q  <= '0;
         burst_vld_q  <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         ack_q        <= ack_d;
         data_q       <= data_d;
         chan_q       <= chan_d;
         ostb_q       <= ostb_d;
         count_q      <= count_d;
`ifdef TX_STREAM_ARB_BURST_EN
         burst_cnt_q  <= burst_cnt_d;
         burst_vld_q  <= burst_vld_d;
`endif
      end
   end

   assign bus.input_streams_ack  = ack_q;
   assign bus.output_stream      = data_q;
   assign bus.output_stream_chan = chan_q;
   assign bus.output_stream_stb  = ostb_q;
   assign bus.output_count       = count_q;
   assign dbg_state              = state_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tx_stream_arbiter
// Directed bench for tx_stream_arbiter. Per-channel source queues feed the
// producers; each test pushes the hand-ordered {chan, data} words it expects
// into exp_q, and a monitor pops and compares on every output transfer.
// ---------------------------------------------------------------------------
module tb_tx_stream_arbiter;
   localparam int CHANNELS  = 4;
   localparam int WIDTH     = 32;
   localparam int CHAN_BITS = 2;
   localparam int BURST     = 4;
   localparam int EW        = CHAN_BITS + WIDTH;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] dbg_state;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   tx_stream_arbiter_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .CHAN_BITS(CHAN_BITS)) bus ();

   tx_stream_arbiter #(
      .CHANNELS(CHANNELS), .WIDTH(WIDTH), .CHAN_BITS(CHAN_BITS), .BURST(BURST)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [EW-1:0]    exp_q[$];
   logic [WIDTH-1:0] src_q[CHANNELS][$];
   int               n_checks = 0;
   int               n_err    = 0;
   bit               gap_en   = 1'b0;
   int               last_cyc = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] word(input int c, input int k);
      return 32'hA000_0000 | WIDTH'(c << 8) | WIDTH'(k);
   endfunction

   function automatic bit src_busy();
      for (int c = 0; c < CHANNELS; c++)
         if (src_q[c].size() != 0) return 1'b1;
      return 1'b0;
   endfunction

   // ---------------- producer driver ----------------
   // Presents the head of each source queue; pops it after the edge where
   // stb and ack were both high.
   initial begin : producer
      logic [CHANNELS-1:0] pend;
      bus.input_streams     = '0;
      bus.input_streams_stb = '0;
      forever begin
         @(negedge clk);
         #2;
         pend = bus.input_streams_stb & bus.input_streams_ack;
         @(posedge clk);
         #1;
         for (int c = 0; c < CHANNELS; c++) begin
            if (pend[c] && !rst && src_q[c].size() != 0) void'(src_q[c].pop_front());
            if (src_q[c].size() != 0) begin
               bus.input_streams_stb[c]                = 1'b1;
               bus.input_streams[c*WIDTH +: WIDTH]     = src_q[c][0];
            end else begin
               bus.input_streams_stb[c] = 1'b0;
            end
         end
      end
   end

   // ---------------- output monitor ----------------
   initial begin : monitor
      logic [EW-1:0] got, exp;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.output_stream_stb && bus.output_stream_ack) begin
            got = {bus.output_stream_chan, bus.output_stream};
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(got), 64'h0);
            end else begin
               exp = exp_q.pop_front();
               chk("out_word", 64'(got), 64'(exp));
            end
            if (gap_en) begin
               if (last_cyc >= 0) chk("word_spacing", 64'(cyc - last_cyc), 64'd3);
               last_cyc = cyc;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_ostb(input string name);
      int n = 0;
      while (!bus.output_stream_stb && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(bus.output_stream_stb), 64'd1);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || src_busy()) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      @(negedge clk);
   endtask

   // ---------------- directed tests ----------------
   initial begin : main
      logic [WIDTH-1:0]     hold_data;
      logic [CHAN_BITS-1:0] hold_chan;

      bus.output_stream_ack = 1'b0;

      // 1: reset state and idle with no requests
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_out_data", 64'(bus.output_stream), 64'h0);
      chk("rst_out_chan", 64'(bus.output_stream_chan), 64'h0);
      chk("rst_state", 64'(dbg_state), 64'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_acks", 64'(bus.input_streams_ack), 64'h0);
         chk("idle_ostb", 64'(bus.output_stream_stb), 64'h0);
         chk("idle_count", 64'(bus.output_count), 64'h0);
      end

      // 2: single word on ch2, latency and count
      bus.output_stream_ack = 1'b1;
      src_q[2].push_back(32'hDEAD_BEEF);
      exp_q.push_back({2'd2, 32'hDEAD_BEEF});
      @(negedge clk);
      chk("t2_stb_up", 64'(bus.input_streams_stb), 64'h4);
      chk("t2_ack_not_yet", 64'(bus.input_streams_ack), 64'h0);
      @(negedge clk);
      chk("t2_ack2", 64'(bus.input_streams_ack), 64'h4);
      chk("t2_state_accept", 64'(dbg_state), 64'd1);
      chk("t2_ostb_low", 64'(bus.output_stream_stb), 64'h0);
      @(negedge clk);
      chk("t2_ack_drop", 64'(bus.input_streams_ack), 64'h0);
      chk("t2_ostb", 64'(bus.output_stream_stb), 64'h1);
      chk("t2_state_send", 64'(dbg_state), 64'd2);
      drain("t2_drain");
      chk("t2_count", 64'(bus.output_count), 64'd1);

      // 3/4: all four channels requesting continuously
      do_reset();
      bus.output_stream_ack = 1'b1;
      last_cyc = -1;
      gap_en   = 1'b1;
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < 4; k++) src_q[c].push_back(word(c, k));
`ifdef TX_STREAM_ARB_BURST_EN
      for (int c = 0; c < CHANNELS; c++)
         for (int k = 0; k < 4; k++) exp_q.push_back({CHAN_BITS'(c), word(c, k)});
`else
      for (int k = 0; k < 4; k++)
         for (int c = 0; c < CHANNELS; c++) exp_q.push_back({CHAN_BITS'(c), word(c, k)});
`endif
      drain("t3_drain");
      gap_en = 1'b0;
      chk("t3_count", 64'(bus.output_count), 64'd16);

      // 5: consumer stalls 20 cycles in SEND
      do_reset();
      bus.output_stream_ack = 1'b0;
      src_q[1].push_back(32'h1234_5678);
      src_q[3].push_back(32'h0BAD_F00D);
      exp_q.push_back({2'd1, 32'h1234_5678});
      exp_q.push_back({2'd3, 32'h0BAD_F00D});
      wait_ostb("t5_ostb_rise");
      chk("t5_chan", 64'(bus.output_stream_chan), 64'd1);
      chk("t5_data", 64'(bus.output_stream), 64'h1234_5678);
      hold_data = bus.output_stream;
      hold_chan = bus.output_stream_chan;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.output_stream !== hold_data || bus.output_stream_chan !== hold_chan ||
             bus.output_stream_stb !== 1'b1 || bus.input_streams_ack !== '0 ||
             bus.output_count !== 32'd0)
            chk("t5_hold_stable", {32'(bus.output_stream), 32'(bus.input_streams_ack)},
                {32'(hold_data), 32'h0});
         else
            n_checks++;
      end
      bus.output_stream_ack = 1'b1;
      @(negedge clk);
      chk("t5_count_one", 64'(bus.output_count), 64'd1);
      drain("t5_drain");
      chk("t5_count", 64'(bus.output_count), 64'd2);

      // 6: reset while a ch1 word waits in SEND
      do_reset();
      bus.output_stream_ack = 1'b0;
      src_q[1].push_back(32'h1111_0001);
      wait_ostb("t6_ostb_rise");
      chk("t6_chan", 64'(bus.output_stream_chan), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t6_ostb_cleared", 64'(bus.output_stream_stb), 64'h0);
      chk("t6_count_cleared", 64'(bus.output_count), 64'h0);
      chk("t6_data_cleared", 64'(bus.output_stream), 64'h0);
      chk("t6_state_idle", 64'(dbg_state), 64'd0);
      bus.output_stream_ack = 1'b1;
      src_q[0].push_back(32'h2222_0000);
      src_q[1].push_back(32'h2222_0001);
      exp_q.push_back({2'd0, 32'h2222_0000});
      exp_q.push_back({2'd1, 32'h2222_0001});
      drain("t6_drain");
      chk("t6_count", 64'(bus.output_count), 64'd2);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
